load_store_unit: RTL and testbench

//  Initiator side of the word-wide data memory interface (async read, sync write, WE).

---
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-wide data memory port.
// Accepts byte/half/word loads and stores from the datapath.
// Sub-word stores use a read-modify-write sequence through a merge buffer.
// Loads return the selected lane, sign- or zero-extended.
// Optional feature macro: LSU_ALIGN_CHECK_EN. When defined, misaligned halves/words
// and the illegal size code produce an error response. When undefined, the low
// address bits are cleared, size 11 is treated as word, and resp_err is tied to 0.
//
// Handshake: a request is taken on a rising edge where req && ready. The requester
// holds req and its fields until ready is high. Completion is a single-cycle
// resp_valid pulse; resp_err qualifies that pulse. A req seen outside IDLE is ignored.
module load_store_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [1:0]        state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] buf_q;

  logic [1:0]        eff_size;
  logic [ADDR_W+1:0] eff_addr;
  logic              req_err;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merge_val;

  // Address bits above the word index wrap and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q;

  // Decode the incoming request: flag misalignment and the illegal size code.
  always_comb begin
    eff_size = req_size;
    eff_addr = req_addr[ADDR_W+1:0];
    req_err  = (req_size == 2'b11) ||
               ((req_size == SZ_H) && req_addr[0]) ||
               ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  end

  assign resp_err = (state == S_RESP) && err_q;
`else
  // Decode the incoming request: force alignment and treat size 11 as word.
  always_comb begin
    eff_size = (req_size == 2'b11) ? SZ_W : req_size;
    eff_addr = req_addr[ADDR_W+1:0];
    if (eff_size == SZ_H) eff_addr[0] = 1'b0;
    if (eff_size == SZ_W) eff_addr[1:0] = 2'b00;
    req_err  = 1'b0;
  end

  assign resp_err = 1'b0;
`endif

  // Extract the addressed lane from the memory word and extend it.
  always_comb begin
    load_val = mem_rdata;
    case (size_q)
      SZ_B: begin
        case (addr_q[1:0])
          2'd0:    load_val[7:0] = mem_rdata[7:0];
          2'd1:    load_val[7:0] = mem_rdata[15:8];
          2'd2:    load_val[7:0] = mem_rdata[23:16];
          default: load_val[7:0] = mem_rdata[31:24];
        endcase
        load_val[31:8] = {24{sext_q & load_val[7]}};
      end
      SZ_H: begin
        load_val[15:0]  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val[31:16] = {16{sext_q & load_val[15]}};
      end
      default: load_val = mem_rdata;
    endcase
  end

  // Replace the addressed lane(s) of the merge buffer with the store data.
  always_comb begin
    merge_val = buf_q;
    if (size_q == SZ_B) begin
      case (addr_q[1:0])
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) merge_val[31:16] = wdata_q[15:0];
      else           merge_val[15:0]  = wdata_q[15:0];
    end
  end

  // Memory-side drive; rst gates the write strobe so no write happens during reset.
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_we     = rst && (((state == S_ACCESS) && we_q && (size_q == SZ_W)) ||
                              (state == S_WRITE));
  assign mem_wdata  = (state == S_WRITE) ? merge_val : wdata_q;
  assign ready      = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign dbg_state  = state;

  // Control FSM and request/response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      resp_rdata <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q    <= req_we;
            size_q  <= eff_size;
            sext_q  <= req_sext;
            addr_q  <= eff_addr;
            wdata_q <= req_wdata;
`ifdef LSU_ALIGN_CHECK_EN
            err_q   <= req_err;
`endif
            state   <= req_err ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (we_q) begin
            if (size_q == SZ_W) begin
              state <= S_RESP;
            end else begin
              buf_q <= mem_rdata;
              state <= S_WRITE;
            end
          end else begin
            resp_rdata <= load_val;
            state      <= S_RESP;
          end
        end
        S_WRITE: state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a behavioural
// word memory (async read, sync write). Builds with or without LSU_ALIGN_CHECK_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int rv_cnt   = 0;

  load_store_unit #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
    .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .ready(ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock and memory model.
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (resp_valid) rv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait for the response; lat counts edges from accept to resp_valid.
  task automatic txn(input logic we, input logic [1:0] size, input logic sext,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output int lat, output logic err, output logic [7:0] acc_addr);
    int guard;
    @(negedge clk);
    req = 1'b1; req_we = we; req_size = size; req_sext = sext;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    acc_addr = mem_addr;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    err = resp_err;
  endtask

  int          lat;
  logic        err;
  logic [7:0]  aa;
  int          we0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // 1: reset held with a store request pending; nothing may be written.
    req = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h12345678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_no_we", 32'(we_cnt), 32'd0);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_mem4", mem[4], 32'h0);

    // 2: word store then word load at 0x10.
    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, aa);
    check("wst_lat", 32'(lat), 32'd2);
    check("wst_addr", {24'd0, aa}, 32'd4);
    @(negedge clk);
    check("wst_mem", mem[4], 32'hDEADBEEF);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, aa);
    check("wld_lat", 32'(lat), 32'd2);
    check("wld_addr", {24'd0, aa}, 32'd4);
    check("wld_data", resp_rdata, 32'hDEADBEEF);
    check("wld_err", {31'd0, err}, 32'd0);

    // 3: byte store into lane 3, then signed and unsigned byte loads.
    mem[4] = 32'h11223344;
    txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA, lat, err, aa);
    check("bst_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check("bst_mem", mem[4], 32'hAA223344);
    txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, err, aa);
    check("bld_sext", resp_rdata, 32'hFFFFFFAA);
    txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, err, aa);
    check("bld_zext", resp_rdata, 32'h000000AA);
    txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, err, aa);
    check("bld_lane1", resp_rdata, 32'h00000033);

    // 4: half store into upper half of word 1, then half loads.
    mem[1] = 32'h0;
    txn(1'b1, 2'b01, 1'b0, 32'h06, 32'h00008001, lat, err, aa);
    check("hst_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check("hst_mem", mem[1], 32'h80010000);
    txn(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, lat, err, aa);
    check("hld_sext", resp_rdata, 32'hFFFF8001);
    txn(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, lat, err, aa);
    check("hld_zext", resp_rdata, 32'h00008001);

    // 5: misaligned half load and illegal size.
    mem[1] = 32'h80011234;
    we0 = we_cnt;
`ifdef LSU_ALIGN_CHECK_EN
    txn(1'b0, 2'b01, 1'b1, 32'h05, 32'h0, lat, err, aa);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_err", {31'd0, err}, 32'd1);
    check("mis_rdata", resp_rdata, 32'h00008001);
    txn(1'b1, 2'b11, 1'b0, 32'h08, 32'hCAFEF00D, lat, err, aa);
    check("ill_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("ill_mem", mem[2], 32'h0);
    check("err_no_we", 32'(we_cnt - we0), 32'd0);
`else
    txn(1'b0, 2'b01, 1'b1, 32'h05, 32'h0, lat, err, aa);
    check("mis_lat", 32'(lat), 32'd2);
    check("mis_err", {31'd0, err}, 32'd0);
    check("mis_rdata", resp_rdata, 32'h00001234);
    check("mis_no_we", 32'(we_cnt - we0), 32'd0);
    txn(1'b1, 2'b11, 1'b0, 32'h0B, 32'hCAFEF00D, lat, err, aa);
    check("ill_lat", 32'(lat), 32'd2);
    check("ill_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("ill_mem", mem[2], 32'hCAFEF00D);
`endif

    // 6: reset while a byte store sits in WRITE; the pending write is dropped.
    mem[3] = 32'h55667788;
    we0 = we_cnt;
    rv_cnt = 0;
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_sext = 1'b0;
    req_addr = 32'h0C; req_wdata = 32'h00000099;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("abort_access", {30'd0, dbg_state}, 32'd1);
    @(negedge clk);
    check("abort_write", {30'd0, dbg_state}, 32'd2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_mem", mem[3], 32'h55667788);
    check("abort_no_we", 32'(we_cnt - we0), 32'd0);
    check("abort_no_resp", 32'(rv_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
